// File: rtl/count_pwm_gen.sv
`default_nettype none
// ============================================================================
// count_pwm_gen: PWM from a free-running up-counter with period-aligned duty
// shadowing, counter-sequence tracking and a completed-period count.
// Revision: 1.0
// ============================================================================
module count_pwm_gen #(
  parameter int WIDTH  = 4,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              enable,
  input  logic [WIDTH-1:0]  duty_in,
  input  logic              duty_load,
  output logic              pwm_out,
  output logic              period_end,
  output logic              duty_ack,
  output logic              sync_err,
  output logic [WIDTH-1:0]  duty_active,
  output logic [PCNT_W-1:0] period_cnt
);

  localparam logic [WIDTH-1:0]  C_MAX  = '1;
  localparam logic [WIDTH-1:0]  C_ONE  = WIDTH'(1);
  localparam logic [PCNT_W-1:0] C_PONE = PCNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    prev_q;
  logic [WIDTH-1:0]    pending_q, pending_d;
  logic                pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0]    duty_q, duty_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic                pwm_q, pwm_d;
  logic                pend_q, pend_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                w_boundary;
  logic [WIDTH-1:0]    w_expect;

  assign w_expect = prev_q + C_ONE;

  always_comb begin
    state_d    = state_q;
    pwm_d      = 1'b0;
    pend_d     = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    duty_d     = duty_q;
    pcnt_d     = pcnt_q;
    pending_d  = duty_load ? duty_in : pending_q;
    pend_vld_d = pend_vld_q;
    w_boundary = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) state_d = SYNC;
      end
      SYNC: begin
        if (count_in == C_MAX) begin
          state_d    = RUN;
          w_boundary = 1'b1;
        end
      end
      RUN: begin
        // A stall or a jump both count as a broken sequence.
        if (count_in != w_expect) begin
          err_d   = 1'b1;
          state_d = SYNC;
        end else begin
          pwm_d = (count_in < duty_q);
          if (count_in == C_MAX) begin
            w_boundary = 1'b1;
            pend_d     = 1'b1;
            pcnt_d     = pcnt_q + C_PONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d    = IDLE;
      pwm_d      = 1'b0;
      pend_d     = 1'b0;
      err_d      = 1'b0;
      pcnt_d     = pcnt_q;
      w_boundary = 1'b0;
    end

    // The pending value as it stood before this edge is what gets applied;
    // a load on the same edge lands in the shadow for the next boundary.
    if (w_boundary && pend_vld_q) begin
      duty_d     = pending_q;
      ack_d      = 1'b1;
      pend_vld_d = 1'b0;
    end
    if (duty_load) pend_vld_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      pending_q  <= '0;
      pend_vld_q <= 1'b0;
      duty_q     <= '0;
      pcnt_q     <= '0;
      pwm_q      <= 1'b0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= count_in;
      pending_q  <= pending_d;
      pend_vld_q <= pend_vld_d;
      duty_q     <= duty_d;
      pcnt_q     <= pcnt_d;
      pwm_q      <= pwm_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_end  = pend_q;
  assign duty_ack    = ack_q;
  assign sync_err    = err_q;
  assign duty_active = duty_q;
  assign period_cnt  = pcnt_q;

endmodule
`default_nettype wire
